// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: IDLE -> LOAD -> 10 round slots -> DONE.
// Each round slot lasts ROUND_CYCLES cycles and strobes round_en in its last cycle.
// The round_idx/mix_en/rcon outputs are decoded from registered state.
// start_ready is the one exception: it is the IDLE decode gated by the abort input.
// Optional feature: define AES_CTRL_PERF_CNT_EN to add the blk_count output.
// blk_count is a saturating 16-bit count of completed output handshakes.
module aes_round_ctrl #(
    parameter int ROUND_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_valid,
    output logic       start_ready,
    input  logic       abort,
    output logic       dp_load,
    output logic       round_en,
    output logic [3:0] round_idx,
    output logic       mix_en,
    output logic [7:0] rcon,
    output logic       busy,
    output logic       done_valid,
    input  logic       done_ready
`ifdef AES_CTRL_PERF_CNT_EN
    ,
    output logic [15:0] blk_count
`endif
);

    typedef enum logic [1:0] {IDLE, LOAD, ROUND, DONE} state_t;

    localparam logic [1:0] SLOT_LAST  = 2'(ROUND_CYCLES - 1);
    localparam logic [3:0] LAST_ROUND = 4'd10;

    state_t     state, state_next;
    logic [1:0] slot_cnt;
    logic       slot_end;

    assign slot_end = (slot_cnt == SLOT_LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic; abort wins over every other transition outside IDLE
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start_valid && !abort) state_next = LOAD;
            LOAD:  state_next = abort ? IDLE : ROUND;
            ROUND: begin
                if (abort)                                   state_next = IDLE;
                else if (slot_end && round_idx == LAST_ROUND) state_next = DONE;
            end
            DONE:  if (abort || done_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Round/slot counters; round_idx is held at 0 whenever the next state is not ROUND
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            round_idx <= 4'd0;
            slot_cnt  <= 2'd0;
        end else if (state_next != ROUND) begin
            round_idx <= 4'd0;
            slot_cnt  <= 2'd0;
        end else if (state == LOAD) begin
            round_idx <= 4'd1;
            slot_cnt  <= 2'd0;
        end else if (slot_end) begin
            round_idx <= round_idx + 4'd1;
            slot_cnt  <= 2'd0;
        end else begin
            slot_cnt  <= slot_cnt + 2'd1;
        end
    end

    // Output decode from registered state
    always_comb begin
        start_ready = (state == IDLE) && !abort;
        dp_load     = (state == LOAD);
        round_en    = (state == ROUND) && slot_end;
        mix_en      = (state == ROUND) && (round_idx != LAST_ROUND);
        busy        = (state != IDLE);
        done_valid  = (state == DONE);
    end

    // Key-schedule round constant; round_idx is 0 outside ROUND so rcon falls to 00
    always_comb begin
        rcon = 8'h00;
        case (round_idx)
            4'd1:  rcon = 8'h01;
            4'd2:  rcon = 8'h02;
            4'd3:  rcon = 8'h04;
            4'd4:  rcon = 8'h08;
            4'd5:  rcon = 8'h10;
            4'd6:  rcon = 8'h20;
            4'd7:  rcon = 8'h40;
            4'd8:  rcon = 8'h80;
            4'd9:  rcon = 8'h1B;
            4'd10: rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

`ifdef AES_CTRL_PERF_CNT_EN
    // Completed-block counter; a handshake coinciding with abort still counts
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            blk_count <= 16'h0000;
        else if (state == DONE && done_ready && blk_count != 16'hFFFF)
            blk_count <= blk_count + 16'h0001;
    end
`endif

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: four instances (ROUND_CYCLES 1..4) share stimulus and are
// each checked every cycle against a cycle-offset model, plus directed literal checks.
module tb_aes_round_ctrl;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_valid = 1'b0;
    logic abort = 1'b0;
    logic done_ready = 1'b0;

    logic [N-1:0]       start_ready, dp_load, round_en, mix_en, busy, done_valid;
    logic [N-1:0][3:0]  round_idx;
    logic [N-1:0][7:0]  rcon;
`ifdef AES_CTRL_PERF_CNT_EN
    logic [N-1:0][15:0] blk_count;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0] rcon_lit [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        aes_round_ctrl #(.ROUND_CYCLES(g + 1)) u_dut (
            .clk(clk), .rst(rst),
            .start_valid(start_valid), .start_ready(start_ready[g]),
            .abort(abort), .dp_load(dp_load[g]), .round_en(round_en[g]),
            .round_idx(round_idx[g]), .mix_en(mix_en[g]), .rcon(rcon[g]),
            .busy(busy[g]), .done_valid(done_valid[g]), .done_ready(done_ready)
`ifdef AES_CTRL_PERF_CNT_EN
            , .blk_count(blk_count[g])
`endif
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Model: k = cycles elapsed since start acceptance (0 = idle). Cycle 1 is LOAD,
    // cycles 2..1+10*rc are rounds, from 2+10*rc the block is done.
    int k   [N];
    int cnt [N];

    initial for (int i = 0; i < N; i++) begin k[i] = 0; cnt[i] = 0; end

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                k[i]   <= 0;
                cnt[i] <= 0;
            end else if (k[i] == 0) begin
                if (start_valid && !abort) k[i] <= 1;
            end else if (k[i] >= 2 + 10 * (i + 1)) begin
                if (done_ready && cnt[i] < 65535) cnt[i] <= cnt[i] + 1;
                if (done_ready || abort) k[i] <= 0;
            end else if (abort) begin
                k[i] <= 0;
            end else begin
                k[i] <= k[i] + 1;
            end
        end
    end

    // Packed {start_ready, dp_load, round_en, round_idx, mix_en, rcon, busy, done_valid}
    function automatic logic [17:0] model_out(input int rc, input int kk, input logic ab);
        logic sr, dl, re, me, bz, dv;
        logic [3:0] ri;
        logic [7:0] rk;
        int r;
        sr = 0; dl = 0; re = 0; me = 0; bz = 0; dv = 0; ri = 0; rk = 0;
        if (kk == 0) sr = !ab;
        else begin
            bz = 1;
            if (kk == 1) dl = 1;
            else if (kk < 2 + 10 * rc) begin
                r  = (kk - 2) / rc + 1;
                ri = 4'(r);
                re = ((kk - 2) % rc) == rc - 1;
                me = (r != 10);
                rk = rcon_lit[r - 1];
            end else dv = 1;
        end
        return {sr, dl, re, ri, me, rk, bz, dv};
    endfunction

    function automatic logic [17:0] dut_out(input int i);
        return {start_ready[i], dp_load[i], round_en[i], round_idx[i], mix_en[i],
                rcon[i], busy[i], done_valid[i]};
    endfunction

    // Every-cycle comparison of all instances against the model
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            chk($sformatf("model_rc%0d", i + 1), 32'(dut_out(i)),
                32'(model_out(i + 1, rst ? 0 : k[i], abort)));
`ifdef AES_CTRL_PERF_CNT_EN
            chk($sformatf("blk_count_rc%0d", i + 1), 32'(blk_count[i]), 32'(cnt[i]));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy != '0 && n < 200) begin tick(); n++; end
        chk("idle_timeout", 32'(busy != '0), 32'd0);
    endtask

    initial begin
        // Reset state
        #1;
        chk("reset_vec", 32'(dut_out(0)), 32'h20000);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Run A: RC=1 latency and rcon sequence, done_ready held 1
        done_ready  = 1'b1;
        start_valid = 1'b1;                       // cycle 0
        tick(); start_valid = 1'b0;               // cycle 1
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk); #1;
            if (c == 1) chk("A_dp_load", 32'(dp_load[0]), 32'd1);
            if (c >= 2 && c <= 11) begin
                chk("A_round_en", 32'(round_en[0]), 32'd1);
                chk("A_round_idx", 32'(round_idx[0]), 32'(c - 1));
                chk("A_rcon", 32'(rcon[0]), 32'(rcon_lit[c - 2]));
                chk("A_mix_en", 32'(mix_en[0]), 32'(c != 11));
            end
            if (c == 12) chk("A_done_valid", 32'(done_valid[0]), 32'd1);
            if (c == 13) chk("A_idle", 32'(busy[0]), 32'd0);
            tick();
        end
        wait_idle();

        // Run B: RC=3 with done_ready withheld for 5 done cycles
        done_ready  = 1'b0;
        start_valid = 1'b1;
        tick(); start_valid = 1'b0;
        for (int c = 1; c <= 38; c++) begin
            @(negedge clk); #1;
            if (c == 31) chk("B_not_done", 32'(done_valid[2]), 32'd0);
            if (c >= 32 && c <= 37) chk("B_done_held", 32'(done_valid[2]), 32'd1);
            if (c == 38) chk("B_idle", 32'(busy[2]), 32'd0);
            tick();
            if (c + 1 == 37) done_ready = 1'b1;
        end
        wait_idle();

        // Run C: abort during round 4 of the RC=1 instance (cycle 5)
        start_valid = 1'b1;
        tick(); start_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk); #1;
            if (c == 5) chk("C_round4", 32'(round_idx[0]), 32'd4);
            if (c == 6) begin
                chk("C_idle", 32'(busy[0]), 32'd0);
                chk("C_start_ready", 32'(start_ready[0]), 32'd1);
            end
            if (c >= 6) chk("C_no_done", 32'(done_valid), 32'd0);
            tick();
            abort = (c + 1 == 5);
        end

        // Run D: reset pulse during round 6, then a fresh block
        start_valid = 1'b1;
        tick(); start_valid = 1'b0;
        for (int c = 1; c < 7; c++) tick();      // now in cycle 7 (round 6)
        chk("D_round6", 32'(round_idx[0]), 32'd6);
        rst = 1'b1;
        #1;
        chk("D_reset_vec", 32'(dut_out(0)), 32'h20000);
        tick();
        rst = 1'b0;
        start_valid = 1'b1;                       // first cycle after release: cycle 0
        tick(); start_valid = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk); #1;
            if (c == 11) chk("D_not_done", 32'(done_valid[0]), 32'd0);
            if (c == 12) chk("D_done", 32'(done_valid[0]), 32'd1);
            tick();
        end
        wait_idle();

        // Random phase
        for (int n = 0; n < 4000; n++) begin
            start_valid = ($urandom_range(0, 1) == 1);
            abort       = ($urandom_range(0, 39) == 0);
            done_ready  = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 599) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
            tick();
        end

        abort = 1'b0;
        start_valid = 1'b0;
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
